uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding and the default oversample ratio.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OSR_DEFAULT = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;
`endif

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input; 2 clk_i latency, no backpressure.
// RESET_VAL is the value both flops take during reset (idle level of the source).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN); byte delivered at the stop-bit midpoint.
// Single-entry output register with valid/ready; a byte arriving while the register is full is dropped (overrun_o).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OSR    = OSR_DEFAULT,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              en_i,
  input  logic              osr_tick_i,
  input  logic              rx_i,
  input  logic              rx_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              rx_valid_o,
  output logic              frame_err_o,
  output logic              overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic              parity_err_o,
`endif
  output logic              busy_o
);

  localparam int TICK_W = $clog2(OSR);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OSR / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OSR - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

  logic rx_s;

  rx_state_t          state_d, state_q;
  logic [TICK_W-1:0]  tick_cnt_d, tick_cnt_q;
  logic [BIT_W-1:0]   bit_cnt_d, bit_cnt_q;
  logic [DATA_W-1:0]  shift_d, shift_q;
  logic [DATA_W-1:0]  data_d, data_q;
  logic               valid_d, valid_q;
  logic               frame_err_d, frame_err_q;
  logic               overrun_d, overrun_q;
  logic               deliver;
`ifdef UART_RX_PARITY_EN
  logic               parity_err_d, parity_err_q;
  logic               par_bad_d, par_bad_q;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (rx_i),
    .q_o      (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif

    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    if (!en_i) begin
      state_d    = IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (osr_tick_i) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          // Re-check the line at the start-bit midpoint to reject glitches.
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
`endif
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            // Shifting in at the MSB lands the first (LSB) bit at position 0 after DATA_W samples.
            shift_d    = {rx_s, shift_q[DATA_W-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d   = '0;
            parity_err_d = (^shift_q) ^ rx_s;
            par_bad_d    = (^shift_q) ^ rx_s;
            state_d      = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              deliver = !par_bad_q;
`else
              deliver = 1'b1;
`endif
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      endcase
    end

    // A read in the same cycle frees the register, so the new byte can replace it.
    if (deliver) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OSR=16, one tick every 4 clk_i, 64 clk_i per bit.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       en_i;
  logic       osr_tick_i;
  logic       rx_i;
  logic       rx_ready_i;
  logic [7:0] data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
  int         pe_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;

  logic [1:0] tdiv = 2'd0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) tdiv <= tdiv + 2'd1;
  assign osr_tick_i = (tdiv == 2'd3);

  // Count asserted cycles so a stuck-high pulse shows up as a count above one.
  always @(posedge clk_i) begin
    if (frame_err_o) fe_cnt <= fe_cnt + 1;
    if (overrun_o)   ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err_o) pe_cnt <= pe_cnt + 1;
`endif
  end

  uart_rx #(
    .OSR    (16),
    .DATA_W (8)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .en_i         (en_i),
    .osr_tick_i   (osr_tick_i),
    .rx_i         (rx_i),
    .rx_ready_i   (rx_ready_i),
    .data_o       (data_o),
    .rx_valid_o   (rx_valid_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (parity_err_o),
`endif
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_bit(input logic v);
    rx_i = v;
    wait_clk(64);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] b, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_b);
    send_bit(stop_b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    send_frame_p(b, stop_b, ^b);
  endtask
`else
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_b);
  endtask
`endif

  initial begin
    logic [7:0] partial;
    reset_ni   = 1'b0;
    en_i       = 1'b1;
    rx_i       = 1'b1;
    rx_ready_i = 1'b0;

    // Reset state
    #23;
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", data_o, 8'h00);
    check("rst_busy", busy_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overrun", overrun_o, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    wait_clk(20);

    // 0xA5 received and held until the consumer is ready
    send_frame(8'hA5, 1'b1);
    wait_clk(10);
    check("a5_data", data_o, 8'hA5);
    check("a5_valid", rx_valid_o, 1);
    check("a5_frame_err", fe_cnt, 0);
    check("a5_busy", busy_o, 0);
    wait_clk(100);
    check("a5_valid_held", rx_valid_o, 1);
    rx_ready_i = 1'b1;
    wait_clk(1);
    rx_ready_i = 1'b0;
    check("a5_valid_cleared", rx_valid_o, 0);
    wait_clk(20);

    // False start: 4 ticks low then high
    rx_i = 1'b0;
    wait_clk(12);
    check("fs_busy_during", busy_o, 1);
    wait_clk(4);
    rx_i = 1'b1;
    wait_clk(80);
    check("fs_busy", busy_o, 0);
    check("fs_valid", rx_valid_o, 0);
    check("fs_frame_err", fe_cnt, 0);

    // 0x3C with a zero stop bit, line held low into BREAK
    send_frame(8'h3C, 1'b0);
    rx_i = 1'b0;
    wait_clk(64);
    check("fe_pulse_cycles", fe_cnt, 1);
    check("fe_valid", rx_valid_o, 0);
    check("fe_busy_break", busy_o, 1);
    rx_i = 1'b1;
    wait_clk(20);
    check("fe_busy_idle", busy_o, 0);
    wait_clk(40);

    // Overrun: 0x11 then 0x22 with no reads
    send_frame(8'h11, 1'b1);
    wait_clk(20);
    send_frame(8'h22, 1'b1);
    wait_clk(20);
    check("ov_pulse_cycles", ov_cnt, 1);
    check("ov_data_kept", data_o, 8'h11);
    check("ov_valid", rx_valid_o, 1);

    // Reset asserted during bit 3 of a 0x5A frame
    partial = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    rx_i = partial[3];
    wait_clk(32);
    #2;
    reset_ni = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid_o, 0);
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_frame_err", frame_err_o, 0);
    check("mid_rst_overrun", overrun_o, 0);
    rx_i = 1'b1;
    wait_clk(4);
    reset_ni = 1'b1;
    wait_clk(128);
    send_frame(8'h5A, 1'b1);
    wait_clk(10);
    check("post_rst_data", data_o, 8'h5A);
    check("post_rst_valid", rx_valid_o, 1);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_no_fe", fe_cnt, 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a zero parity bit is an even-parity mismatch
    rx_ready_i = 1'b1;
    wait_clk(1);
    rx_ready_i = 1'b0;
    wait_clk(20);
    send_frame_p(8'h07, 1'b1, 1'b0);
    wait_clk(10);
    check("par_pulse_cycles", pe_cnt, 1);
    check("par_valid", rx_valid_o, 0);
    check("par_no_fe", fe_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
